// File: rtl/base_red_xor_acc.sv
// rtl/base_red_xor_acc.sv - registered XOR reducer with per-beat and frame-accumulate modes
module base_red_xor_acc #(
   parameter int ways  = 2,
   parameter int width = 8,
   parameter int cntw  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_v,
   output logic                    i_r,
   input  logic [ways*width-1:0]   i_d,
   input  logic                    i_last,
   input  logic                    i_mode,
   output logic                    o_v,
   input  logic                    o_r,
   output logic [width-1:0]        o_d,
   output logic [cntw-1:0]         o_cnt
);

   localparam logic [cntw-1:0] CNT_MAX = '1;
   localparam logic [cntw-1:0] CNT_ONE = cntw'(1);

   logic [width-1:0] r_acc;
   logic [cntw-1:0]  r_cnt;
   logic             r_active;
   logic             r_mode;
   logic             r_o_v;
   logic [width-1:0] r_o_d;
   logic [cntw-1:0]  r_o_cnt;

   logic [width-1:0] w_red;
   logic             w_accept;
   logic             w_mode;
   logic             w_emit;
   logic [cntw-1:0]  w_cnt_next;

   // Fold all words of the incoming beat into one word.
   always_comb begin
      w_red = '0;
      for (int k = 0; k < ways; k++) begin
         w_red = w_red ^ i_d[k*width +: width];
      end
   end

   // No skid buffer: input only moves when the output register is free or draining.
   assign i_r        = ~r_o_v | o_r;
   assign w_accept   = i_v & i_r;
   // The mode of a frame comes from its first beat; later beats use the latched copy.
   assign w_mode     = r_active ? r_mode : i_mode;
   // Mode 0 emits on every beat; mode 1 only on the last beat of the frame.
   assign w_emit     = ~w_mode | i_last;
   assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

   // Frame accumulator, beat counter and output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc    <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_mode   <= 1'b0;
         r_o_v    <= 1'b0;
         r_o_d    <= '0;
         r_o_cnt  <= '0;
      end else if (w_accept) begin
         r_mode <= w_mode;
         if (w_emit) begin
            r_o_v    <= 1'b1;
            r_o_d    <= r_acc ^ w_red;
            r_o_cnt  <= w_cnt_next;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
         end else begin
            r_acc    <= r_acc ^ w_red;
            r_cnt    <= w_cnt_next;
            r_active <= 1'b1;
         end
      end else if (r_o_v & o_r) begin
         r_o_v <= 1'b0;
      end
   end

   assign o_v   = r_o_v;
   assign o_d   = r_o_d;
   assign o_cnt = r_o_cnt;

endmodule

// File: tb/tb_base_red_xor_acc.sv
// tb/tb_base_red_xor_acc.sv - self-checking bench for base_red_xor_acc
module tb_base_red_xor_acc;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_v;
   logic [15:0] i_d;
   logic        i_last;
   logic        i_mode;
   logic        o_r;
   logic        i_r, i_r2;
   logic        o_v, o_v2;
   logic [7:0]  o_d, o_d2;
   logic [7:0]  o_cnt;
   logic [1:0]  o_cnt2;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit       e_ov;
   bit [7:0] e_od;
   int       e_c8, e_c2;
   bit       exp_ir, obs_ir;
   bit       m_active, m_mode;
   bit [7:0] m_acc;
   int       m_count;

   always #5 clk = ~clk;

   base_red_xor_acc #(.ways(2), .width(8), .cntw(8)) dut (
      .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_d(i_d), .i_last(i_last),
      .i_mode(i_mode), .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_cnt(o_cnt));

   base_red_xor_acc #(.ways(2), .width(8), .cntw(2)) dut2 (
      .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r2), .i_d(i_d), .i_last(i_last),
      .i_mode(i_mode), .o_v(o_v2), .o_r(o_r), .o_d(o_d2), .o_cnt(o_cnt2));

   task automatic model_reset();
      e_ov = 0; e_od = 0; e_c8 = 0; e_c2 = 0;
      m_active = 0; m_mode = 0; m_acc = 0; m_count = 0;
   endtask

   // One clock cycle: present inputs, predict the result from the frame rules, advance.
   task automatic tick(input bit v, input bit [15:0] d, input bit last, input bit mode, input bit orr);
      bit       accepted;
      bit [7:0] red;
      int       cnt;
      @(negedge clk);
      i_v = v; i_d = d; i_last = last; i_mode = mode; o_r = orr;
      #1;
      obs_ir   = i_r;
      exp_ir   = !e_ov || orr;
      accepted = v && exp_ir;
      if (accepted) begin
         if (!m_active) m_mode = mode;
         red = d[7:0] ^ d[15:8];
         if (!m_mode || last) begin
            cnt      = m_count + 1;
            e_ov     = 1;
            e_od     = m_acc ^ red;
            e_c8     = (cnt > 255) ? 255 : cnt;
            e_c2     = (cnt > 3) ? 3 : cnt;
            m_acc    = 0;
            m_count  = 0;
            m_active = 0;
         end else begin
            m_acc    = m_acc ^ red;
            m_count  = m_count + 1;
            m_active = 1;
         end
      end else if (e_ov && orr) begin
         e_ov = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1; i_v = 0; i_d = 0; i_last = 0; i_mode = 0; o_r = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({o_v, o_d, o_cnt, o_v2, o_d2, o_cnt2, i_r} !== {1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 2'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state: got v=%0b d=%h cnt=%0d v2=%0b d2=%h cnt2=%0d ir=%0b, want 0/00/0/0/00/0 ir=1",
                  o_v, o_d, o_cnt, o_v2, o_d2, o_cnt2, i_r);
      end
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_mode0();
      bit [15:0] beats [3];
      bit [7:0]  want  [3];
      beats = '{16'hF00F, 16'h55AA, 16'h1212};
      want  = '{8'hFF, 8'hFF, 8'h00};
      for (int i = 0; i < 3; i++) begin
         tick(1, beats[i], 0, 0, 1);
         n_tests++;
         if ({o_v, o_d, o_cnt, o_cnt2} !== {1'b1, want[i], 8'd1, 2'd1}) begin
            n_fail++;
            $display("FAIL mode0_beat%0d: got v=%0b d=%h cnt=%0d cnt2=%0d, want 1/%h/1/1", i, o_v, o_d, o_cnt, o_cnt2, want[i]);
         end
      end
      tick(0, 0, 0, 0, 1);
      n_tests++;
      if ({o_v, o_d} !== {1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL mode0_drain: got v=%0b d=%h, want 0/00", o_v, o_d);
      end
   endtask

   task automatic test_mode1();
      bit [15:0] beats [3];
      beats = '{16'h0201, 16'h0804, 16'h2010};
      for (int i = 0; i < 3; i++) begin
         tick(1, beats[i], i == 2, 1, 1);
         if (i < 2) begin
            n_tests++;
            if (o_v !== 1'b0) begin
               n_fail++;
               $display("FAIL mode1_early_v%0d: got v=%0b, want 0", i, o_v);
            end
         end
      end
      n_tests++;
      if ({o_v, o_d, o_cnt, o_cnt2} !== {1'b1, 8'h3F, 8'd3, 2'd3}) begin
         n_fail++;
         $display("FAIL mode1_result: got v=%0b d=%h cnt=%0d cnt2=%0d, want 1/3f/3/3", o_v, o_d, o_cnt, o_cnt2);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 2; i++) begin
         tick(1, 16'h7777, 1, 0, 0);
         n_tests++;
         if ({obs_ir, o_v, o_d, o_cnt} !== {1'b0, 1'b1, 8'h3F, 8'd3}) begin
            n_fail++;
            $display("FAIL hold_%0d: got ir=%0b v=%0b d=%h cnt=%0d, want 0/1/3f/3", i, obs_ir, o_v, o_d, o_cnt);
         end
      end
      tick(1, 16'h2211, 1, 0, 1);
      n_tests++;
      if ({obs_ir, o_v, o_d, o_cnt} !== {1'b1, 1'b1, 8'h33, 8'd1}) begin
         n_fail++;
         $display("FAIL back_to_back: got ir=%0b v=%0b d=%h cnt=%0d, want 1/1/33/1", obs_ir, o_v, o_d, o_cnt);
      end
      tick(0, 0, 0, 0, 1);
      n_tests++;
      if ({o_v, o_d, o_cnt} !== {1'b0, 8'h33, 8'd1}) begin
         n_fail++;
         $display("FAIL hold_release: got v=%0b d=%h cnt=%0d, want 0/33/1", o_v, o_d, o_cnt);
      end
   endtask

   task automatic test_mode_toggle();
      tick(1, 16'h0001, 0, 1, 1);
      tick(1, 16'h0002, 0, 0, 1);
      n_tests++;
      if (o_v !== 1'b0) begin
         n_fail++;
         $display("FAIL toggle_ignored: got v=%0b, want 0", o_v);
      end
      tick(1, 16'h0004, 1, 0, 1);
      n_tests++;
      if ({o_v, o_d, o_cnt} !== {1'b1, 8'h07, 8'd3}) begin
         n_fail++;
         $display("FAIL toggle_result: got v=%0b d=%h cnt=%0d, want 1/07/3", o_v, o_d, o_cnt);
      end
      tick(1, 16'h0005, 0, 0, 1);
      tick(1, 16'h0006, 0, 0, 1);
      n_tests++;
      if ({o_v, o_d, o_cnt} !== {1'b1, 8'h06, 8'd1}) begin
         n_fail++;
         $display("FAIL toggle_next_mode0: got v=%0b d=%h cnt=%0d, want 1/06/1", o_v, o_d, o_cnt);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 5; i++) tick(1, 16'h0001, i == 4, 1, 1);
      n_tests++;
      if ({o_v2, o_d2, o_cnt2, o_d, o_cnt} !== {1'b1, 8'h01, 2'd3, 8'h01, 8'd5}) begin
         n_fail++;
         $display("FAIL saturate: got v2=%0b d2=%h cnt2=%0d d=%h cnt=%0d, want 1/01/3/01/5",
                  o_v2, o_d2, o_cnt2, o_d, o_cnt);
      end
   endtask

   task automatic test_reset_mid();
      tick(1, 16'h00F0, 0, 1, 1);
      tick(1, 16'h0F00, 0, 1, 1);
      @(negedge clk);
      i_v = 1; i_d = 16'hFFFF; i_last = 1; reset = 1;
      #1;
      n_tests++;
      if ({o_v, o_d, o_cnt} !== {1'b0, 8'h00, 8'd0}) begin
         n_fail++;
         $display("FAIL async_reset: got v=%0b d=%h cnt=%0d, want 0/00/0", o_v, o_d, o_cnt);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 0; i_v = 0;
      tick(1, 16'h003C, 1, 1, 1);
      n_tests++;
      if ({o_v, o_d, o_cnt} !== {1'b1, 8'h3C, 8'd1}) begin
         n_fail++;
         $display("FAIL after_reset: got v=%0b d=%h cnt=%0d, want 1/3c/1", o_v, o_d, o_cnt);
      end
   endtask

   task automatic test_random();
      bit        v, last, mode, orr;
      bit [15:0] d;
      for (int i = 0; i < 400; i++) begin
         v    = ($urandom_range(3) != 0);
         last = ($urandom_range(2) == 0);
         mode = ($urandom_range(2) != 0);
         orr  = ($urandom_range(3) != 0);
         d    = 16'($urandom);
         tick(v, d, last, mode, orr);
         n_tests++;
         if (obs_ir !== exp_ir) begin
            n_fail++;
            $display("FAIL random_ir cyc%0d: got %0b, want %0b", i, obs_ir, exp_ir);
         end
         n_tests++;
         if ({o_v, o_d, o_cnt, o_v2, o_d2, o_cnt2} !== {e_ov, e_od, 8'(e_c8), e_ov, e_od, 2'(e_c2)}) begin
            n_fail++;
            $display("FAIL random_out cyc%0d: got v=%0b d=%h cnt=%0d cnt2=%0d, want v=%0b d=%h cnt=%0d cnt2=%0d",
                     i, o_v, o_d, o_cnt, o_cnt2, e_ov, e_od, e_c8, e_c2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode1();
      test_hold();
      test_mode_toggle();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
